// File: rtl/bsg_dll_cal_ctrl_if.sv
// Calibration controller bus: enable/phase in, code and status out.
// Slave side is the controller; master side drives en/phase.
interface bsg_dll_cal_ctrl_if #(
  parameter int code_width_p = 6
);
  logic                    en_i;
  logic                    phase_i;
  logic [code_width_p-1:0] dly_code_o;
  logic                    busy_o;
  logic                    locked_o;
  logic                    err_o;

  modport master (
    output en_i, phase_i,
    input  dly_code_o, busy_o, locked_o, err_o
  );

  modport slave (
    input  en_i, phase_i,
    output dly_code_o, busy_o, locked_o, err_o
  );
endinterface

// File: rtl/bsg_dll_cal_ctrl.sv
// DLL calibration controller: linear search for lock, then
// unanimous-vote tracking of the delay-line control code.
module bsg_dll_cal_ctrl #(
  parameter int code_width_p = 6,
  parameter int settle_p     = 8,
  parameter int samples_p    = 5
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bsg_dll_cal_ctrl_if.slave   bus
);

  localparam int ones_w_lp = $clog2(samples_p + 1);

  localparam logic [7:0] settle_last_lp = 8'(settle_p - 1);
  localparam logic [7:0] samp_last_lp   = 8'(samples_p - 1);
  localparam logic [ones_w_lp-1:0] ones_all_lp =
    ones_w_lp'(samples_p);
  localparam logic [code_width_p-1:0] code_max_lp = '1;

  typedef enum logic [2:0] {
    IDLE, SETTLE, SAMPLE, UPDATE, FAIL
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ones_w_lp-1:0]    ones_q, ones_d;
  logic [code_width_p-1:0] code_q, code_d;
  logic                    locked_q, locked_d;
  logic                    err_q, err_d;

  logic vote_short, all_short, all_long;

  // Majority and unanimity of the collected phase samples
  always_comb begin
    vote_short = (2 * int'(ones_q)) > samples_p;
    all_short  = (ones_q == ones_all_lp);
    all_long   = (ones_q == '0);
  end

  // Next-state, counter and code update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    code_d   = code_q;
    locked_d = locked_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en_i) begin
          state_d  = SETTLE;
          code_d   = '0;
          locked_d = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          ones_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == settle_last_lp) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        ones_d = ones_q + ones_w_lp'(bus.phase_i);
        if (cnt_q == samp_last_lp) begin
          state_d = UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      UPDATE: begin
        state_d = SETTLE;
        ones_d  = '0;
        if (!locked_q) begin
          if (vote_short) begin
            if (code_q != code_max_lp) begin
              code_d = code_q + 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = FAIL;
            end
          end else if (code_q != '0) begin
            locked_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = FAIL;
          end
        end else begin
          if (all_short && code_q != code_max_lp) begin
            code_d = code_q + 1'b1;
          end else if (all_long && code_q != '0) begin
            code_d = code_q - 1'b1;
          end
        end
      end
      FAIL: begin
        if (!bus.en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable aborts from anywhere, freezing the code
    if (!bus.en_i && state_q != IDLE) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      cnt_d    = '0;
      ones_d   = '0;
      code_d   = code_q;
      err_d    = err_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ones_q   <= '0;
      code_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      code_q   <= code_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.dly_code_o = code_q;
  assign bus.locked_o   = locked_q;
  assign bus.err_o      = err_q;
  assign bus.busy_o     = (state_q == SETTLE) ||
                          (state_q == SAMPLE) ||
                          (state_q == UPDATE);

endmodule

// File: tb/tb_bsg_dll_cal_ctrl.sv
// Bench for bsg_dll_cal_ctrl: directed and random vote steps
// checked against a step-level model of the calibration rules.
module tb_bsg_dll_cal_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_dll_cal_ctrl_if #(.code_width_p(6)) bus();

  bsg_dll_cal_ctrl #(
    .code_width_p(6),
    .settle_p(8),
    .samples_p(5)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  int m_code;
  bit m_locked;
  bit m_err;
  bit m_fail;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One vote step applied to the model
  task automatic model_step(input logic [4:0] pat);
    int ones;
    ones = $countones(pat);
    if (!m_locked) begin
      if (2 * ones > 5) begin
        if (m_code < 63) m_code++;
        else begin m_err = 1; m_fail = 1; end
      end else if (m_code > 0) begin
        m_locked = 1;
      end else begin
        m_err = 1; m_fail = 1;
      end
    end else begin
      if (ones == 5 && m_code < 63) m_code++;
      else if (ones == 0 && m_code > 0) m_code--;
    end
  endtask

  // Drive one full settle/sample/update step and check its result
  task automatic step(input string tag, input logic [4:0] pat);
    bit busy_ok;
    busy_ok = 1;
    for (int i = 0; i < 8; i++) begin
      bus.phase_i = 1'($urandom);
      @(negedge clk);
      if (bus.busy_o !== 1'b1) busy_ok = 0;
    end
    for (int j = 0; j < 5; j++) begin
      bus.phase_i = pat[j];
      @(negedge clk);
      if (bus.busy_o !== 1'b1) busy_ok = 0;
    end
    bus.phase_i = 1'($urandom);
    @(negedge clk);
    model_step(pat);
    chk({tag, "_busy_in_step"}, 32'(busy_ok), 32'd1);
    chk({tag, "_code"}, 32'(bus.dly_code_o), 32'(m_code));
    chk({tag, "_locked"}, 32'(bus.locked_o), 32'(m_locked));
    chk({tag, "_err"}, 32'(bus.err_o), 32'(m_err));
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'(!m_fail));
  endtask

  task automatic start(input string tag);
    bus.en_i = 1'b1;
    @(negedge clk);
    m_code = 0; m_locked = 0; m_err = 0; m_fail = 0;
    chk({tag, "_start_code"}, 32'(bus.dly_code_o), 32'd0);
    chk({tag, "_start_busy"}, 32'(bus.busy_o), 32'd1);
    chk({tag, "_start_err"}, 32'(bus.err_o), 32'd0);
  endtask

  task automatic stop();
    bus.en_i = 1'b0;
    @(negedge clk);
    m_locked = 0;
    m_fail = 1;
  endtask

  function automatic logic [4:0] three_of_five();
    logic [4:0] p;
    p = 5'b00111;
    for (int k = 0; k < 5; k++) begin
      int r;
      logic t;
      r = $urandom_range(4, 0);
      t = p[k]; p[k] = p[r]; p[r] = t;
    end
    return p;
  endfunction

  initial begin
    int n;
    bus.en_i = 1'b0;
    bus.phase_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_code", 32'(bus.dly_code_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_locked", 32'(bus.locked_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lock at 10: 11 steps of 14 cycles
    start("lock");
    for (int s = 0; s < 11; s++)
      step("lock", (m_code < 10) ? 5'h1f : 5'h00);
    chk("lock_final_locked", 32'(bus.locked_o), 32'd1);
    chk("lock_final_code", 32'(bus.dly_code_o), 32'd10);

    // Tracking: noisy votes hold, unanimous moves by one
    for (int s = 0; s < 3; s++) step("trk_noisy", three_of_five());
    chk("trk_noisy_hold", 32'(bus.dly_code_o), 32'd10);
    step("trk_up", 5'h1f);
    step("trk_up", 5'h1f);
    chk("trk_at12", 32'(bus.dly_code_o), 32'd12);
    for (int s = 0; s < 12; s++) begin
      case ($urandom_range(2, 0))
        0: step("trk_rand", 5'h1f);
        1: step("trk_rand", 5'h00);
        default: step("trk_rand", 5'($urandom));
      endcase
    end
    n = m_code + 2;
    for (int s = 0; s < n; s++) step("trk_down", 5'h00);
    chk("trk_floor_code", 32'(bus.dly_code_o), 32'd0);
    chk("trk_floor_err", 32'(bus.err_o), 32'd0);
    chk("trk_floor_locked", 32'(bus.locked_o), 32'd1);
    stop();

    // Abort mid-SAMPLE at code 6, then restart
    start("abort");
    for (int s = 0; s < 6; s++) step("abort", 5'h1f);
    repeat (10) begin
      bus.phase_i = 1'b1;
      @(negedge clk);
    end
    bus.en_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_code", 32'(bus.dly_code_o), 32'd6);
    chk("abort_locked", 32'(bus.locked_o), 32'd0);
    start("restart");
    step("restart", 5'h1f);
    stop();

    // Upper saturation at 63
    start("sat");
    for (int s = 0; s < 64; s++) step("sat", 5'h1f);
    chk("sat_err", 32'(bus.err_o), 32'd1);
    chk("sat_code", 32'(bus.dly_code_o), 32'd63);
    repeat (3) @(negedge clk);
    chk("fail_hold_err", 32'(bus.err_o), 32'd1);
    chk("fail_hold_busy", 32'(bus.busy_o), 32'd0);
    chk("fail_hold_code", 32'(bus.dly_code_o), 32'd63);
    bus.en_i = 1'b0;
    @(negedge clk);
    chk("idle_keep_err", 32'(bus.err_o), 32'd1);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);

    // Lower boundary: long on the first step
    start("low");
    step("low", 5'h00);
    chk("low_err", 32'(bus.err_o), 32'd1);
    chk("low_code", 32'(bus.dly_code_o), 32'd0);
    stop();

    // Random search until the model fails or a step budget ends
    for (int r = 0; r < 4; r++) begin
      start("rnd");
      for (int s = 0; s < 30 && !m_fail; s++)
        step("rnd", 5'($urandom));
      stop();
    end

    // Asynchronous reset while locked at 10
    start("rlock");
    for (int s = 0; s < 11; s++)
      step("rlock", (m_code < 10) ? 5'h1f : 5'h00);
    chk("rlock_locked", 32'(bus.locked_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", 32'(bus.dly_code_o), 32'd0);
    chk("arst_locked", 32'(bus.locked_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_err", 32'(bus.err_o), 32'd0);
    bus.en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
